regfile: RTL and testbench

General-purpose register file for the five-stage MIPS core. It terminates the write-back bus driven by the MEM/WB pipeline register: it accepts one register write per cycle and serves the ID stage's two operand read ports. A third read-only debug port is provided for the bench. It also bypasses a same-cycle write-back to any read port, so ID never sees a stale value from the instruction retiring that cycle.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_rdport.sv | 33 +++
 rtl/regfile.sv | 74 +++++++
 tb/tb_regfile.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file of the five-stage core.
// Widths mirror the core-wide register address and data bus definitions.
package regfile_pkg;

  localparam int REGADDRBUS = 5;
  localparam int REGBUS     = 32;
  localparam int REGNUM     = 32;

  localparam logic [REGBUS-1:0]     ZEROWORD   = '0;
  localparam logic [REGADDRBUS-1:0] NOPREGADDR = '0;

  localparam logic WRITEENABLE = 1'b1;
  localparam logic READENABLE  = 1'b1;

  // This block's reset is active-low regardless of the core-wide reset level.
  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: reset, enable, zero-register and same-cycle
// write-back bypass are resolved here in priority order.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGADDRBUS,
  parameter int DATA_W = REGBUS
) (
  input  logic              i_rst_n,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [DATA_W-1:0] o_rdata
);

  // Bypass compares the full index so ID sees the value retiring this cycle.
  always_comb begin
    o_rdata = i_rword;
    if (i_rst_n == RST_ACTIVE) begin
      o_rdata = ZEROWORD;
    end else if (i_re != READENABLE) begin
      o_rdata = ZEROWORD;
    end else if (i_raddr == NOPREGADDR) begin
      o_rdata = ZEROWORD;
    end else if (i_we == WRITEENABLE && i_waddr == i_raddr) begin
      o_rdata = i_wdata;
    end
  end

endmodule

// File: rtl/regfile.sv
// Register file terminating the MEM/WB write-back bus: one write per cycle,
// two ID operand read ports and an always-enabled debug read port.
module regfile
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = REGADDRBUS,
  parameter int DATA_W  = REGBUS,
  parameter int REG_NUM = REGNUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic              w_wr_commit;

  // Register 0 is never written, so it stays at its reset value of zero.
  assign w_wr_commit = (i_we == WRITEENABLE) && (i_waddr != NOPREGADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= ZEROWORD;
      end
    end else if (w_wr_commit) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  regfile_rdport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rdport1 (
    .i_rst_n (rst_n),
    .i_re    (i_re1),
    .i_raddr (i_raddr1),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_rword (r_regs[i_raddr1]),
    .o_rdata (o_rdata1)
  );

  regfile_rdport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rdport2 (
    .i_rst_n (rst_n),
    .i_re    (i_re2),
    .i_raddr (i_raddr2),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_rword (r_regs[i_raddr2]),
    .o_rdata (o_rdata2)
  );

  regfile_rdport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rdport_dbg (
    .i_rst_n (rst_n),
    .i_re    (1'b1),
    .i_raddr (i_dbg_addr),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_rword (r_regs[i_dbg_addr]),
    .o_rdata (o_dbg_data)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random traffic,
// all compared against an array model of the architectural registers.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [31:0] model [32];
  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (we),
    .i_waddr    (waddr),
    .i_wdata    (wdata),
    .i_re1      (re1),
    .i_raddr1   (raddr1),
    .o_rdata1   (rdata1),
    .i_re2      (re2),
    .i_raddr2   (raddr2),
    .o_rdata2   (rdata2),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data)
  );

  // Every comparison goes through here so the counters stay consistent.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Architectural view of a read: what ID should see for this index right now.
  function automatic logic [31:0] expectRead(input logic en, input logic [4:0] addr);
    if (!rst_n || !en || addr == 5'd0) return 32'h0;
    if (we && waddr == addr) return wdata;
    return model[addr];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one cycle's worth of inputs; a low reset clears storage immediately.
  task automatic applyStimulus(input logic rstv, input logic wev, input logic [4:0] wa,
                               input logic [31:0] wd, input logic r1, input logic [4:0] a1,
                               input logic r2, input logic [4:0] a2, input logic [4:0] da);
    rst_n = rstv; we = wev; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2; dbg_addr = da;
    if (!rstv) clearModel();
    #1;
  endtask

  task automatic checkPorts(input string tag);
    checkOutput({tag, "_rd1"}, rdata1, expectRead(re1, raddr1));
    checkOutput({tag, "_rd2"}, rdata2, expectRead(re2, raddr2));
    checkOutput({tag, "_dbg"}, dbg_data, expectRead(1'b1, dbg_addr));
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (rst_n && we && waddr != 5'd0) model[waddr] = wdata;
    #1;
  endtask

  initial begin
    clearModel();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2, 5'd3);
    #10;
    checkPorts("reset");
    checkOutput("reset_dbg_const", dbg_data, 32'h0);

    // Write then read, with enable low forcing zero.
    applyStimulus(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0, 5'd8, 5'd8);
    checkPorts("wr_rd");
    checkOutput("wr_rd_r1", rdata1, 32'hDEAD_BEEF);
    checkOutput("wr_rd_re0", rdata2, 32'h0);
    clockEdge();

    // Zero register rejects writes and never bypasses.
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    checkOutput("zero_byp_r1", rdata1, 32'h0);
    checkOutput("zero_byp_dbg", dbg_data, 32'h0);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    checkOutput("zero_r1", rdata1, 32'h0);
    checkOutput("zero_dbg", dbg_data, 32'h0);
    clockEdge();

    // Bypass to all three ports at once, then the stored value.
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h2, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3);
    checkPorts("byp");
    checkOutput("byp_r1", rdata1, 32'h2);
    checkOutput("byp_r2", rdata2, 32'h2);
    checkOutput("byp_dbg", dbg_data, 32'h2);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3);
    checkOutput("byp_next_r1", rdata1, 32'h2);
    checkOutput("byp_next_dbg", dbg_data, 32'h2);
    clockEdge();

    // Independent ports while an unrelated register is written.
    applyStimulus(1'b1, 1'b1, 5'd1, 32'hA, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 5'd2, 32'hB, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b1, 5'd31, 32'hC, 1'b1, 5'd1, 1'b1, 5'd2, 5'd0);
    checkOutput("indep_r1", rdata1, 32'hA);
    checkOutput("indep_r2", rdata2, 32'hB);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd31);
    checkOutput("indep_dbg31", dbg_data, 32'hC);
    clockEdge();

    // Asynchronous reset mid-cycle clears storage before any edge.
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    checkOutput("pre_rst_dbg5", dbg_data, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    checkOutput("async_rst_r1", rdata1, 32'h0);
    checkOutput("async_rst_dbg", dbg_data, 32'h0);
    checkOutput("async_rst_storage5", dut.r_regs[5], 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd8, 5'd5);
    checkOutput("post_rst_r1_5", rdata1, 32'h0);
    checkOutput("post_rst_r2_8", rdata2, 32'h0);
    clockEdge();

    // A write whose edge meets an active reset is lost.
    applyStimulus(1'b0, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
    clockEdge();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd9);
    checkOutput("rst_coll_r1", rdata1, 32'h0);
    checkOutput("rst_coll_dbg", dbg_data, 32'h0);
    clockEdge();

    // Random traffic, addresses kept low half of the time to force collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a [4];
      for (int k = 0; k < 4; k++)
        a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 39) != 0, 1'($urandom), a[0], $urandom,
                    1'($urandom_range(0, 3) != 0), a[1], 1'($urandom_range(0, 3) != 0), a[2], a[3]);
      checkPorts("rand");
      clockEdge();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
